// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port unified memory between instruction fetch (IF,
//   read-only) and the memory stage (DM, load/store). Only one transaction is
//   in flight at a time. DM has fixed priority, but after STARVE_LIMIT
//   consecutive DM wins over a waiting IF, the next grant goes to IF. A
//   taken-branch flush discards the fetch that is in flight. stall_o holds
//   the pipeline while any request is pending.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no transaction in flight; may grant one requester this cycle
//   WAIT   | waiting MEM_LATENCY cycles for mem_rdata; owner gets rsp at end
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req_* / if_rsp_*           fetch request/response (read-only)
//   dm_req_* / dm_rsp_*           load/store request/response
//   flush_i                       taken branch: drop fetch in flight
//   stall_o                       pipeline hold
//   mem_*                         memory port (mem_rdata MEM_LATENCY after mem_en)
//
// Build option
//   ARB_PERF_EN : adds perf_conflict_cnt and perf_starve_cnt (32-bit,
//                 saturating) outputs.
module unified_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  dm_req_valid,
    input  logic                  dm_req_we,
    input  logic [2:0]            dm_req_funct3,
    input  logic [ADDR_WIDTH-1:0] dm_req_addr,
    input  logic [DATA_WIDTH-1:0] dm_req_wdata,
    output logic                  dm_req_ready,
    output logic                  dm_rsp_valid,
    output logic [DATA_WIDTH-1:0] dm_rsp_data,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflict_cnt,
    output logic [31:0]           perf_starve_cnt
`endif
);

    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            store_q, store_d;
    logic            drop_q, drop_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [SW-1:0]   starve_q, starve_d;

    logic if_elig, both_elig, force_if, grant_if, grant_dm, done;

    assign if_elig   = if_req_valid && !flush_i;
    assign both_elig = if_elig && dm_req_valid;
    assign force_if  = both_elig && (starve_q == SW'(STARVE_LIMIT));
    // Grants are suppressed while rst is high so every output reads 0 in reset.
    assign grant_dm  = !rst && (state_q == S_IDLE) && dm_req_valid && !force_if;
    assign grant_if  = !rst && (state_q == S_IDLE) && if_elig && !grant_dm;
    assign done      = !rst && (state_q == S_WAIT) && (lat_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_IF;
            store_q  <= 1'b0;
            drop_q   <= 1'b0;
            lat_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
            drop_q   <= drop_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        store_d      = store_q;
        drop_d       = drop_q;
        lat_d        = lat_q;
        starve_d     = starve_q;
        if_req_ready = grant_if;
        dm_req_ready = grant_dm;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        dm_rsp_valid = 1'b0;
        dm_rsp_data  = '0;
        mem_en       = grant_if || grant_dm;
        mem_we       = 1'b0;
        mem_funct3   = 3'b000;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (grant_dm) begin
            mem_we     = dm_req_we;
            mem_funct3 = dm_req_funct3;
            mem_addr   = dm_req_addr;
            mem_wdata  = dm_req_wdata;
        end else if (grant_if) begin
            mem_funct3 = 3'b010;                  // fetch is always a full word
            mem_addr   = if_req_addr;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_dm || grant_if) begin
                    state_d = S_WAIT;
                    owner_d = grant_dm ? OWN_DM : OWN_IF;
                    store_d = grant_dm && dm_req_we;
                    drop_d  = 1'b0;
                    lat_d   = LW'(MEM_LATENCY - 1);
                end
                if (grant_if) begin
                    starve_d = '0;
                end else if (grant_dm) begin
                    if (!if_elig)
                        starve_d = '0;
                    else if (starve_q != SW'(STARVE_LIMIT))
                        starve_d = starve_q + SW'(1);
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                end else begin
                    lat_d = lat_q - LW'(1);
                    if (flush_i && owner_q == OWN_IF)
                        drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            if (owner_q == OWN_IF) begin
                if_rsp_valid = !drop_q;
                if_rsp_data  = drop_q ? '0 : mem_rdata;
            end else begin
                dm_rsp_valid = 1'b1;
                dm_rsp_data  = store_q ? '0 : mem_rdata;
            end
        end

        stall_o = !rst && ((state_q == S_WAIT) ||
                           (if_req_valid && !if_req_ready) ||
                           (dm_req_valid && !dm_req_ready));
    end

`ifdef ARB_PERF_EN
    logic idle_act;
    assign idle_act = !rst && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
            perf_starve_cnt   <= '0;
        end else begin
            if (idle_act && both_elig && perf_conflict_cnt != 32'hFFFF_FFFF)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            if (idle_act && force_if && perf_starve_cnt != 32'hFFFF_FFFF)
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready, if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid = 1'b0, dm_req_we = 1'b0;
    logic [2:0]  dm_req_funct3 = 3'b010;
    logic [31:0] dm_req_addr = '0, dm_req_wdata = '0;
    logic        dm_req_ready, dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        flush_i = 1'b0;
    logic        stall_o, mem_en, mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_conflict_cnt, perf_starve_cnt;
`endif

    unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_funct3(dm_req_funct3),
        .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
        .flush_i(flush_i), .stall_o(stall_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        , .perf_conflict_cnt(perf_conflict_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Memory stub: read data is a hash of the address, returned LAT cycles after mem_en.
    function automatic logic [31:0] fdat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] rdq [0:LAT-1];
    initial for (int i = 0; i < LAT; i++) rdq[i] = 32'hBAD0_BAD0;
    always @(posedge clk) begin
        rdq[0] <= mem_en ? fdat(mem_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
    end
    assign mem_rdata = rdq[LAT-1];

    // Transaction-level model: a grant at cycle n books the memory until n+LAT,
    // the response lands exactly at n+LAT, and the next grant is possible at n+LAT+1.
    int          n = 0;
    int          next_free = 0;
    int          resp_at = -1;
    int          own = 0;               // 1 = IF, 2 = DM
    bit          own_store = 0;
    bit          dropped = 0;
    logic [31:0] own_data = '0;
    int          starve = 0;
    int          m_conflict = 0;
    int          m_forced = 0;
    string       gstr = "";
    int          gcyc[$];

    always @(negedge clk) begin
        logic        e_ifr, e_dmr, e_en, e_we, e_stall, e_ifv, e_dmv;
        logic [2:0]  e_f3;
        logic [31:0] e_addr, e_wd, e_ifd, e_dmd;
        bit          ife, dme;
        int          win;
        e_ifr = 0; e_dmr = 0; e_en = 0; e_we = 0; e_stall = 0; e_ifv = 0; e_dmv = 0;
        e_f3 = '0; e_addr = '0; e_wd = '0; e_ifd = '0; e_dmd = '0; win = 0;
        ife = if_req_valid && !flush_i;
        dme = dm_req_valid;
        if (rst) begin
            next_free = 0; resp_at = -1; starve = 0; dropped = 0;
            m_conflict = 0; m_forced = 0;
        end else if (n >= next_free) begin
            if (ife && dme) begin
                m_conflict++;
                win = (starve == SL) ? 1 : 2;
                if (win == 1) m_forced++;
            end else if (dme) win = 2;
            else if (ife) win = 1;
            if (win == 2) begin
                e_dmr = 1; e_en = 1; e_we = dm_req_we; e_f3 = dm_req_funct3;
                e_addr = dm_req_addr; e_wd = dm_req_wdata;
                starve = ife ? ((starve < SL) ? starve + 1 : SL) : 0;
                own_store = dm_req_we; own_data = fdat(dm_req_addr);
                gstr = {gstr, "D"};
            end else if (win == 1) begin
                e_ifr = 1; e_en = 1; e_addr = if_req_addr;
                starve = 0; own_store = 0; own_data = fdat(if_req_addr);
                gstr = {gstr, "I"};
            end
            if (win != 0) begin
                own = win; next_free = n + LAT + 1; resp_at = n + LAT; dropped = 0;
                gcyc.push_back(n);
            end
            e_stall = (if_req_valid && !e_ifr) || (dm_req_valid && !e_dmr);
        end else begin
            e_stall = 1;
            if (n == resp_at) begin
                if (own == 1 && !dropped) begin e_ifv = 1; e_ifd = own_data; end
                if (own == 2) begin e_dmv = 1; e_dmd = own_store ? 32'h0 : own_data; end
            end
            if (flush_i && own == 1) dropped = 1;
        end

        chk1("if_req_ready", if_req_ready, e_ifr);
        chk1("dm_req_ready", dm_req_ready, e_dmr);
        chk1("mem_en", mem_en, e_en);
        chk1("stall_o", stall_o, e_stall);
        chk1("if_rsp_valid", if_rsp_valid, e_ifv);
        chk1("dm_rsp_valid", dm_rsp_valid, e_dmv);
        if (e_en) begin
            chk32("mem_addr", mem_addr, e_addr);
            chk1("mem_we", mem_we, e_we);
            if (e_dmr) begin
                chk32("mem_funct3", 32'(mem_funct3), 32'(e_f3));
                chk32("mem_wdata", mem_wdata, e_wd);
            end
        end
        if (e_ifv) chk32("if_rsp_data", if_rsp_data, e_ifd);
        if (e_dmv) chk32("dm_rsp_data", dm_rsp_data, e_dmd);
        n++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requesters: keep valid/payload stable until accepted, then move to the next request.
    task automatic run_reqs(input int nif, input int ndm);
        int  k = 0;
        int  ki = 0;
        int  kd = 0;
        bit  acc_if, acc_dm;
        if_req_addr  = 32'h100;
        dm_req_addr  = 32'h200;
        dm_req_we    = 1'b0;
        dm_req_funct3 = 3'b010;
        dm_req_wdata = 32'h1111_0000;
        if_req_valid = (nif > 0);
        dm_req_valid = (ndm > 0);
        while ((ki < nif || kd < ndm) && k < 200) begin
            @(negedge clk);
            acc_if = if_req_valid && if_req_ready;
            acc_dm = dm_req_valid && dm_req_ready;
            step();
            if (acc_if) begin
                ki++;
                if_req_addr  = 32'h100 + 32'(4 * ki);
                if_req_valid = (ki < nif);
            end
            if (acc_dm) begin
                kd++;
                dm_req_addr  = 32'h200 + 32'(4 * kd);
                dm_req_wdata = 32'h1111_0000 + 32'(kd);
                dm_req_valid = (kd < ndm);
            end
            k++;
        end
        chk1("run_reqs_within_budget", (k < 200), 1'b1);
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        repeat (LAT + 1) step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: IF-only fetch at 0x10
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        #1;
        chk1("t1_if_ready_t0", if_req_ready, 1'b1);
        chk1("t1_mem_en_t0", mem_en, 1'b1);
        chk32("t1_mem_addr_t0", mem_addr, 32'h10);
        chk1("t1_mem_we_t0", mem_we, 1'b0);
        step();
        if_req_valid = 1'b0;
        step();
        if_req_valid = 1'b1; if_req_addr = 32'h14;
        #1;
        chk1("t1_rsp_valid_t2", if_rsp_valid, 1'b1);
        chk32("t1_rsp_data_t2", if_rsp_data, fdat(32'h10));
        chk1("t1_no_accept_t2", if_req_ready, 1'b0);
        step();
        #1;
        chk1("t1_accept_t3", if_req_ready, 1'b1);
        step();
        if_req_valid = 1'b0;
        repeat (LAT + 1) step();

        // 2: IF and DM together -> DM first, IF three cycles later
        gstr = ""; gcyc.delete();
        run_reqs(1, 1);
        chk1("t2_order_DI", (gstr == "DI"), 1'b1);
        chk32("t2_if_grant_gap", 32'(gcyc[1] - gcyc[0]), 32'd3);

        // 3: both held valid -> starvation guard forces the 5th grant to IF
        gstr = "";
        run_reqs(2, 6);
        chk1("t3_order_DDDDIDDI", (gstr == "DDDDIDDI"), 1'b1);
        chk32("t3_model_forced", 32'(m_forced), 32'd1);
`ifdef ARB_PERF_EN
        chk32("t3_perf_starve", perf_starve_cnt, 32'd1);
`endif

        // DM-only loads
        run_reqs(0, 3);

        // 4: flush drops the in-flight fetch; flushed request is not accepted
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        step();
        if_req_valid = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        chk1("t4_rsp_dropped_t2", if_rsp_valid, 1'b0);
        step();
        if_req_valid = 1'b1; if_req_addr = 32'h24; flush_i = 1'b1;
        #1;
        chk1("t4_flush_blocks_accept", if_req_ready, 1'b0);
        chk1("t4_flush_stall", stall_o, 1'b1);
        step();
        flush_i = 1'b0;
        #1;
        chk1("t4_accept_after_flush", if_req_ready, 1'b1);
        step();
        if_req_valid = 1'b0;
        repeat (LAT + 1) step();

        // 5: store byte
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_funct3 = 3'b000;
        dm_req_addr = 32'h103; dm_req_wdata = 32'hAB;
        #1;
        chk1("t5_mem_we", mem_we, 1'b1);
        chk32("t5_mem_funct3", 32'(mem_funct3), 32'd0);
        chk32("t5_mem_addr", mem_addr, 32'h103);
        chk32("t5_mem_wdata", mem_wdata, 32'hAB);
        step();
        dm_req_valid = 1'b0; dm_req_we = 1'b0;
        step();
        #1;
        chk1("t5_rsp_valid", dm_rsp_valid, 1'b1);
        chk32("t5_rsp_data", dm_rsp_data, 32'h0);
        repeat (LAT) step();

        // 6: reset during WAIT abandons the fetch
        if_req_valid = 1'b1; if_req_addr = 32'h40;
        step();
        if_req_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk1("t6_if_rsp_valid", if_rsp_valid, 1'b0);
        chk1("t6_dm_rsp_valid", dm_rsp_valid, 1'b0);
        chk32("t6_if_rsp_data", if_rsp_data, 32'h0);
        chk32("t6_dm_rsp_data", dm_rsp_data, 32'h0);
        chk1("t6_stall", stall_o, 1'b0);
        chk1("t6_mem_en", mem_en, 1'b0);
        chk1("t6_mem_we", mem_we, 1'b0);
        chk32("t6_mem_addr", mem_addr, 32'h0);
        chk32("t6_mem_wdata", mem_wdata, 32'h0);
        chk32("t6_mem_funct3", 32'(mem_funct3), 32'd0);
        repeat (LAT + 1) step();

        // post-reset traffic still arbitrates normally
        gstr = "";
        run_reqs(1, 1);
        chk1("t6_post_reset_order", (gstr == "DI"), 1'b1);
`ifdef ARB_PERF_EN
        chk32("perf_conflict_end", perf_conflict_cnt, 32'(m_conflict));
        chk32("perf_starve_end", perf_starve_cnt, 32'(m_forced));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
